// File: rtl/cle_engine.sv
`default_nettype none
// ============================================================================
//  Module      : cle_engine
//  Description : Connected-component labeling engine for a 32x32 binary image
//                with 8-connectivity. Pixels come from a synchronous image
//                ROM; labels are written to a synchronous 1024x8 SRAM.
//                Pass 1 raster-labels with a one-row line buffer and a
//                flattened equivalence table. The table is then compacted to
//                consecutive final labels. Pass 2 rewrites every SRAM word
//                through the table.
//  Revision    : 1.0  initial release
// ============================================================================
module cle_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rom_q,
  output logic [6:0] rom_a,
  input  logic [7:0] sram_q,
  output logic [9:0] sram_a,
  output logic [7:0] sram_d,
  output logic       sram_wen,
  output logic       finish
);

  localparam int         TBL_SIZE  = 255;
  localparam logic [7:0] LABEL_MAX = 8'd255;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,  // load the four ROM bytes of one image row
    S_SCAN    = 3'd1,  // pass 1: one pixel per cycle, provisional labels
    S_COMPACT = 3'd2,  // turn table roots into consecutive final labels
    S_P2_RD   = 3'd3,  // pass 2: present read address
    S_P2_WT   = 3'd4,  // pass 2: SRAM read latency
    S_P2_WR   = 3'd5,  // pass 2: write resolved label back
    S_FLUSH   = 3'd6,  // let the final write commit before finish rises
    S_DONE    = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [9:0]  pix_q, pix_d;          // {row x, column y}
  logic [31:0] row_q, row_d;          // current row bits, pixel y at [31] after y shifts
  logic [7:0]  lb_q [0:31];           // labels: columns < y current row, >= y previous row
  logic [7:0]  lb_d [0:31];
  logic [7:0]  left_q, left_d;        // current-row label at y-1
  logic [7:0]  upleft_q, upleft_d;    // previous-row label at y-1
  logic [7:0]  cnt_q, cnt_d;          // provisional labels allocated
  logic [7:0]  nf_q, nf_d;            // final labels allocated during compaction
  logic [7:0]  k_q, k_d;              // compaction index
  logic [7:0]  tbl_q [1:TBL_SIZE];    // every allocated label -> its current root
  logic [7:0]  tbl_d [1:TBL_SIZE];
  logic [6:0]  rom_a_q, rom_a_d;
  logic [9:0]  sram_a_q, sram_a_d;
  logic [7:0]  sram_d_q, sram_d_d;
  logic        sram_wen_q, sram_wen_d;
  logic        finish_q, finish_d;

  assign rom_a    = rom_a_q;
  assign sram_a   = sram_a_q;
  assign sram_d   = sram_d_q;
  assign sram_wen = sram_wen_q;
  assign finish   = finish_q;

  // Neighbourhood of the pixel being scanned, resolved to table roots.
  logic [4:0] col, col_nx;
  logic [7:0] up_raw, ur_raw;
  logic [7:0] up_root, ur_root, left_root, upleft_root, side_root;
  logic [7:0] new_lab;

  assign col         = pix_q[4:0];
  assign col_nx      = col + 5'd1;
  assign up_raw      = lb_q[col];
  assign ur_raw      = (col == 5'd31) ? 8'd0 : lb_q[col_nx];
  assign up_root     = (up_raw   == 8'd0) ? 8'd0 : tbl_q[up_raw];
  assign ur_root     = (ur_raw   == 8'd0) ? 8'd0 : tbl_q[ur_raw];
  assign left_root   = (left_q   == 8'd0) ? 8'd0 : tbl_q[left_q];
  assign upleft_root = (upleft_q == 8'd0) ? 8'd0 : tbl_q[upleft_q];
  // Left and up-left are vertical neighbours, so they already share a root.
  assign side_root   = (left_root != 8'd0) ? left_root : upleft_root;
  assign new_lab     = cnt_q + 8'd1;

  // Compaction and pass-2 table reads.
  logic [7:0] k_ent, k_ent_fin, p2_lab;
  assign k_ent     = tbl_q[k_q];
  assign k_ent_fin = (k_ent == 8'd0) ? 8'd0 : tbl_q[k_ent];
  assign p2_lab    = (sram_q == 8'd0) ? 8'd0 : tbl_q[sram_q];

  logic [7:0] lab;
  logic       do_new, do_merge;
  logic [7:0] m_lo, m_hi;

  // Pick the label for the scanned pixel. When "up" is set it touches every
  // other labelled neighbour, so the only possible merge is up-right against
  // the left side.
  always_comb begin
    lab      = 8'd0;
    do_new   = 1'b0;
    do_merge = 1'b0;
    m_lo     = 8'd0;
    m_hi     = 8'd0;
    if (row_q[31]) begin
      if (up_root != 8'd0) begin
        lab = up_root;
      end else if (side_root == 8'd0 && ur_root == 8'd0) begin
        if (cnt_q == LABEL_MAX) begin
          // Table exhausted: fold into the last label rather than overflow.
          lab = tbl_q[LABEL_MAX];
        end else begin
          lab    = new_lab;
          do_new = 1'b1;
        end
      end else if (side_root == 8'd0) begin
        lab = ur_root;
      end else if (ur_root == 8'd0) begin
        lab = side_root;
      end else begin
        if (side_root < ur_root) begin
          m_lo = side_root;
          m_hi = ur_root;
        end else begin
          m_lo = ur_root;
          m_hi = side_root;
        end
        lab      = m_lo;
        do_merge = (side_root != ur_root);
      end
    end
  end

  // Next-state and output logic of the sequencer.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    pix_d      = pix_q;
    row_d      = row_q;
    lb_d       = lb_q;
    left_d     = left_q;
    upleft_d   = upleft_q;
    cnt_d      = cnt_q;
    nf_d       = nf_q;
    k_d        = k_q;
    tbl_d      = tbl_q;
    rom_a_d    = rom_a_q;
    sram_a_d   = sram_a_q;
    sram_d_d   = sram_d_q;
    sram_wen_d = 1'b1;
    finish_d   = finish_q;

    unique case (state_q)
      S_FETCH: begin
        // Addresses go out on steps 0..3; data returns two edges later.
        if (step_q < 3'd4) rom_a_d = {pix_q[9:5], step_q[1:0]};
        if (step_q >= 3'd2) row_d = {row_q[23:0], rom_q};
        if (step_q == 3'd5) begin
          step_d  = 3'd0;
          state_d = S_SCAN;
        end else begin
          step_d = step_q + 3'd1;
        end
      end

      S_SCAN: begin
        sram_a_d   = pix_q;
        sram_d_d   = lab;
        sram_wen_d = 1'b0;
        row_d      = row_q << 1;
        lb_d[col]  = lab;
        left_d     = lab;
        upleft_d   = up_raw;
        if (do_merge) begin
          // Keep the table flat: every entry pointing at the losing root
          // now points at the smaller one.
          for (int i = 1; i <= TBL_SIZE; i++) begin
            if (tbl_q[i] == m_hi) tbl_d[i] = m_lo;
          end
        end
        if (do_new) begin
          tbl_d[new_lab] = new_lab;
          cnt_d          = new_lab;
        end
        pix_d = pix_q + 10'd1;
        if (col == 5'd31) begin
          left_d   = 8'd0;
          upleft_d = 8'd0;
          if (pix_q[9:5] == 5'd31) begin
            k_d     = 8'd1;
            nf_d    = 8'd0;
            state_d = S_COMPACT;
          end else begin
            step_d  = 3'd0;
            state_d = S_FETCH;
          end
        end
      end

      S_COMPACT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_P2_RD;
        end else begin
          // Roots are the minimum of their set, so a non-root's root has
          // already been rewritten to its final label.
          if (k_ent == k_q) begin
            tbl_d[k_q] = nf_q + 8'd1;
            nf_d       = nf_q + 8'd1;
          end else begin
            tbl_d[k_q] = k_ent_fin;
          end
          if (k_q == cnt_q) state_d = S_P2_RD;
          else              k_d = k_q + 8'd1;
        end
      end

      S_P2_RD: begin
        sram_a_d = pix_q;
        state_d  = S_P2_WT;
      end

      S_P2_WT: begin
        state_d = S_P2_WR;
      end

      S_P2_WR: begin
        sram_d_d   = p2_lab;
        sram_wen_d = 1'b0;
        pix_d      = pix_q + 10'd1;
        state_d    = (pix_q == 10'd1023) ? S_FLUSH : S_P2_RD;
      end

      S_FLUSH: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        finish_d = 1'b1;
      end

      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  // State register with synchronous active-low reset that restarts at (0,0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      step_q     <= 3'd0;
      pix_q      <= 10'd0;
      row_q      <= 32'd0;
      left_q     <= 8'd0;
      upleft_q   <= 8'd0;
      cnt_q      <= 8'd0;
      nf_q       <= 8'd0;
      k_q        <= 8'd0;
      rom_a_q    <= 7'd0;
      sram_a_q   <= 10'd0;
      sram_d_q   <= 8'd0;
      sram_wen_q <= 1'b1;
      finish_q   <= 1'b0;
      for (int i = 0; i < 32; i++) lb_q[i] <= 8'd0;
      for (int i = 1; i <= TBL_SIZE; i++) tbl_q[i] <= 8'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pix_q      <= pix_d;
      row_q      <= row_d;
      left_q     <= left_d;
      upleft_q   <= upleft_d;
      cnt_q      <= cnt_d;
      nf_q       <= nf_d;
      k_q        <= k_d;
      rom_a_q    <= rom_a_d;
      sram_a_q   <= sram_a_d;
      sram_d_q   <= sram_d_d;
      sram_wen_q <= sram_wen_d;
      finish_q   <= finish_d;
      for (int i = 0; i < 32; i++) lb_q[i] <= lb_d[i];
      for (int i = 1; i <= TBL_SIZE; i++) tbl_q[i] <= tbl_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cle_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cle_engine
//  Description : Self-checking bench for cle_engine. Image vectors come from
//                a table; each run's expectation is queued at start and
//                checked against a flood-fill reference when finish rises.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cle_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rom_q;
  logic [6:0] rom_a;
  logic [7:0] sram_q;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic       finish;

  cle_engine dut (
    .clk      (clk),
    .reset    (reset),
    .rom_q    (rom_q),
    .rom_a    (rom_a),
    .sram_q   (sram_q),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_wen (sram_wen),
    .finish   (finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [1023:0]  img;        // bit x*32+y = pixel (x,y)
    int             exp_ncomp;  // -1: take the count from the reference model
  } vec_t;

  logic [7:0] rom [128];
  logic [7:0] mem [1024];
  bit         written [1024];
  logic       clr_mem = 1'b0;
  logic       clr_wr  = 1'b0;
  int         wr_after_fin = 0;

  int checks = 0;
  int errors = 0;

  vec_t sb_q [$];
  vec_t vecs [9];

  int refl [1024];
  int stk  [1024];
  int rep  [1025];

  // Synchronous ROM and SRAM models plus a write monitor.
  always @(posedge clk) begin
    rom_q  <= rom[rom_a];
    sram_q <= mem[sram_a];
    if (clr_mem) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]     <= 8'h5A;
        written[i] <= 1'b0;
      end
    end else if (clr_wr) begin
      for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
    end else if (!sram_wen) begin
      mem[sram_a]     <= sram_d;
      written[sram_a] <= 1'b1;
      if (finish) wr_after_fin <= wr_after_fin + 1;
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1023:0] setpx(input logic [1023:0] a, input int x, input int y);
    logic [1023:0] r;
    r = a;
    r[x*32 + y] = 1'b1;
    return r;
  endfunction

  task automatic load_rom(input logic [1023:0] img);
    for (int x = 0; x < 32; x++)
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < 8; k++)
          rom[x*4 + b][7-k] = img[x*32 + b*8 + k];
  endtask

  // Reference labeling by 8-connected flood fill.
  task automatic model(input logic [1023:0] img, output int n);
    int sp, q, nx, ny, np;
    n = 0;
    for (int p = 0; p < 1024; p++) refl[p] = 0;
    for (int p = 0; p < 1024; p++) begin
      if (img[p] && refl[p] == 0) begin
        n++;
        refl[p] = n;
        sp = 0;
        stk[sp++] = p;
        while (sp > 0) begin
          q = stk[--sp];
          for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++) begin
              nx = q / 32 + dx;
              ny = q % 32 + dy;
              if (nx >= 0 && nx < 32 && ny >= 0 && ny < 32) begin
                np = nx*32 + ny;
                if (img[np] && refl[np] == 0) begin
                  refl[np] = n;
                  stk[sp++] = np;
                end
              end
            end
        end
      end
    end
  endtask

  task automatic compare_result();
    vec_t e;
    int n, exp_n, unwr, bg_bad, rng_bad, split_bad, distinct;
    bit seen [256];
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    model(e.img, n);
    exp_n = (e.exp_ncomp >= 0) ? e.exp_ncomp : n;
    unwr = 0; bg_bad = 0; rng_bad = 0; split_bad = 0; distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int c = 0; c <= 1024; c++) rep[c] = -1;
    for (int p = 0; p < 1024; p++) begin
      if (!written[p]) unwr++;
      if (refl[p] == 0) begin
        if (mem[p] != 8'h00) bg_bad++;
      end else begin
        if (mem[p] == 8'h00 || mem[p] == 8'hFF) rng_bad++;
        if (rep[refl[p]] < 0) rep[refl[p]] = int'(mem[p]);
        else if (rep[refl[p]] != int'(mem[p])) split_bad++;
      end
    end
    for (int c = 1; c <= n; c++) begin
      if (!seen[rep[c]]) begin
        seen[rep[c]] = 1'b1;
        distinct++;
      end
    end
    check({e.name, "_unwritten"}, unwr, 0);
    check({e.name, "_background"}, bg_bad, 0);
    check({e.name, "_label_range"}, rng_bad, 0);
    check({e.name, "_split"}, split_bad, 0);
    check({e.name, "_ncomp"}, distinct, exp_n);
  endtask

  task automatic run_vec(input vec_t v, input bit mid_reset);
    int cyc, bad, wf;
    @(negedge clk);
    reset   = 1'b0;
    clr_mem = 1'b1;
    load_rom(v.img);
    repeat (2) @(posedge clk);
    #1;
    check({v.name, "_reset_state"}, {finish, sram_wen, rom_a, sram_a, sram_d},
          {1'b0, 1'b1, 7'd0, 10'd0, 8'd0});
    @(negedge clk);
    clr_mem = 1'b0;
    sb_q.push_back(v);
    wf = wr_after_fin;
    reset = 1'b1;
    if (mid_reset) begin
      repeat (600) @(posedge clk);
      #1;
      check({v.name, "_finish_before_abort"}, finish, 0);
      @(negedge clk);
      reset  = 1'b0;
      clr_wr = 1'b1;
      for (int i = 0; i < 2; i++) begin
        @(posedge clk);
        #1;
        check({v.name, "_abort_outputs"}, {finish, sram_wen, rom_a, sram_a, sram_d},
              {1'b0, 1'b1, 7'd0, 10'd0, 8'd0});
      end
      @(negedge clk);
      clr_wr = 1'b0;
      reset  = 1'b1;
    end
    cyc = 0;
    while (!finish && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({v.name, "_finish_in_bound"}, finish, 1);
    if (mid_reset) check({v.name, "_restart_full_run"}, (cyc >= 1024), 1);
    compare_result();
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (finish !== 1'b1 || sram_wen !== 1'b1) bad++;
    end
    check({v.name, "_hold_after_finish"}, bad, 0);
    check({v.name, "_writes_after_finish"}, wr_after_fin - wf, 0);
  endtask

  initial begin
    logic [1023:0] im;
    vec_t mv;

    im = '0;
    vecs[0].name = "all_zero";  vecs[0].img = im;  vecs[0].exp_ncomp = 0;

    im = setpx('0, 0, 0);
    vecs[1].name = "single";    vecs[1].img = im;  vecs[1].exp_ncomp = 1;

    im = setpx(setpx('0, 0, 0), 1, 1);
    vecs[2].name = "diagonal";  vecs[2].img = im;  vecs[2].exp_ncomp = 1;

    im = setpx('0, 2, 2);
    for (int x = 2; x <= 4; x++) for (int y = 10; y <= 12; y++) im = setpx(im, x, y);
    for (int x = 2; x <= 8; x++) begin im = setpx(im, x, 20); im = setpx(im, x, 24); end
    for (int y = 20; y <= 24; y++) im = setpx(im, 8, y);
    for (int y = 0; y < 32; y++) im = setpx(im, 14, y);
    for (int i = 0; i < 12; i++) im = setpx(im, 20 + i, 30 - i);
    vecs[3].name = "five_blobs"; vecs[3].img = im; vecs[3].exp_ncomp = 5;

    im = '1;
    vecs[4].name = "all_ones";  vecs[4].img = im;  vecs[4].exp_ncomp = 1;

    im = '0;
    for (int x = 0; x < 32; x++) for (int y = 0; y < 32; y++)
      if ((x + y) % 2 == 0) im = setpx(im, x, y);
    vecs[5].name = "checker";   vecs[5].img = im;  vecs[5].exp_ncomp = 1;

    im = setpx(setpx(setpx(setpx('0, 0, 31), 1, 0), 5, 31), 6, 0);
    vecs[6].name = "row_wrap";  vecs[6].img = im;  vecs[6].exp_ncomp = 4;

    for (int w = 0; w < 32; w++) im[w*32 +: 32] = $urandom & $urandom;
    vecs[7].name = "random_a";  vecs[7].img = im;  vecs[7].exp_ncomp = -1;

    for (int w = 0; w < 32; w++) im[w*32 +: 32] = $urandom & ($urandom | $urandom);
    vecs[8].name = "random_b";  vecs[8].img = im;  vecs[8].exp_ncomp = -1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

    mv = vecs[8];
    mv.name = "mid_reset";
    run_vec(mv, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
